m_in_tx: RTL and testbench

Transmit-side packetizer that produces the engine's input beat stream (`m_pkg::in_t`) from a byte-serial source. It packs bytes little-end-first into 4-byte beats and generates `sop`, `eop` and `length`. It sits between a host byte source and the match engine's `in_t` port. It buffers one output beat and applies valid/accept backpressure on both sides.

---
 rtl/m_in_tx.sv | 89 ++++++++
 tb/tb_m_in_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/m_in_tx.sv
// Byte-serial to 4-byte beat packetizer feeding the match engine input port.
// Output beat layout: {sop, eop, length[2:0], data[31:0]}, data lane 0 = first byte.
module m_in_tx #(
    parameter int MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_vld,
    input  logic [7:0]  byte_w,
    input  logic        byte_last,
    output logic        byte_accept,
    output logic        in_vld_r,
    output logic [36:0] in_r,
    input  logic        in_accept,
    output logic [15:0] pkt_cnt_r,
    output logic        err_oversize_r
);

    localparam int WORD_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(MAX_WORDS - 1);

    logic [3:0][7:0]    acc_reg;
    logic [3:0][7:0]    lane_next;
    logic [1:0]         idx_reg;
    logic [WORD_W-1:0]  word_reg;
    logic               sop_pend_reg;
    logic               take;
    logic               close;
    logic               out_take;
    logic [36:0]        beat_next;

    // Stalling every byte (not just closing ones) keeps accept a pure function of the output slot.
    assign byte_accept = !in_vld_r || in_accept;
    assign take        = byte_vld && byte_accept;
    assign close       = take && (idx_reg == 2'd3 || byte_last);
    assign out_take    = in_vld_r && in_accept;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_next[gi] = (take && idx_reg == 2'(gi)) ? byte_w : acc_reg[gi];
        end
    endgenerate

    assign beat_next = {sop_pend_reg, byte_last, {1'b0, idx_reg} + 3'd1, lane_next};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg        <= '0;
            idx_reg        <= 2'd0;
            word_reg       <= '0;
            sop_pend_reg   <= 1'b1;
            in_vld_r       <= 1'b0;
            in_r           <= '0;
            pkt_cnt_r      <= 16'd0;
            err_oversize_r <= 1'b0;
        end else begin
            if (take) begin
                if (close) begin
                    acc_reg      <= '0;
                    idx_reg      <= 2'd0;
                    sop_pend_reg <= byte_last;
                    if (byte_last) begin
                        word_reg <= '0;
                    end else if (word_reg == WORD_LAST) begin
                        // Packet keeps flowing; counter saturates and the flag latches.
                        err_oversize_r <= 1'b1;
                    end else begin
                        word_reg <= word_reg + 1'b1;
                    end
                end else begin
                    acc_reg <= lane_next;
                    idx_reg <= idx_reg + 2'd1;
                end
            end

            if (close) begin
                in_vld_r <= 1'b1;
                in_r     <= beat_next;
            end else if (out_take) begin
                in_vld_r <= 1'b0;
            end

            if (out_take && in_r[35]) begin
                pkt_cnt_r <= pkt_cnt_r + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_m_in_tx.sv
// Directed and soak bench for m_in_tx, run with MAX_WORDS=2 so oversize is reachable.
module tb_m_in_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        byte_vld;
    logic [7:0]  byte_w;
    logic        byte_last;
    logic        byte_accept;
    logic        in_vld_r;
    logic [36:0] in_r;
    logic        in_accept;
    logic [15:0] pkt_cnt_r;
    logic        err_oversize_r;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [36:0] got_q[$];
    logic [7:0]  src_q[$];
    logic [36:0] hold;
    logic        done;

    m_in_tx #(.MAX_WORDS(2)) dut (
        .clk(clk), .rst(rst), .byte_vld(byte_vld), .byte_w(byte_w), .byte_last(byte_last),
        .byte_accept(byte_accept), .in_vld_r(in_vld_r), .in_r(in_r), .in_accept(in_accept),
        .pkt_cnt_r(pkt_cnt_r), .err_oversize_r(err_oversize_r)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Beats taken downstream are collected away from the active edge.
    always @(negedge clk) begin
        if (in_vld_r === 1'b1 && in_accept === 1'b1) begin
            got_q.push_back(in_r);
            $display("beat sop=%0d eop=%0d len=%0d data=%h", in_r[36], in_r[35], in_r[34:32], in_r[31:0]);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [36:0] mk(input logic sop, input logic eop, input logic [2:0] len,
                                       input logic [31:0] d);
        return {sop, eop, len, d};
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n;
        n = 0;
        byte_vld = 1'b1; byte_w = b; byte_last = last;
        forever begin
            @(negedge clk);
            if (byte_accept) break;
            n++;
            if (n > 200) begin
                check("send_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk); #1;
        byte_vld = 1'b0; byte_last = 1'b0;
    endtask

    task automatic expect_beat(input string tag, input logic [36:0] exp);
        logic [36:0] g;
        if (got_q.size() == 0) begin
            check({tag, "_missing"}, 0, 1);
        end else begin
            g = got_q.pop_front();
            check(tag, g, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int t0, len, mism, bad_len, bad_sop, eops;
        logic prev_eop;
        logic [36:0] g;
        logic [7:0] rebuilt[$];

        rst = 1'b1; byte_vld = 1'b0; byte_w = 8'h00; byte_last = 1'b0; in_accept = 1'b1; done = 1'b0;
        wait_cycles(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_vld", in_vld_r, 0);
        check("rst_in_r", in_r, 0);
        check("rst_pkt", pkt_cnt_r, 0);
        check("rst_err", err_oversize_r, 0);
        check("rst_accept", byte_accept, 1);
        @(posedge clk); #1;
        got_q.delete();

        // Basic 8-byte packet, also checks latency and full-rate throughput.
        t0 = cyc;
        for (int i = 1; i <= 8; i++) begin
            send_byte(8'(i), i == 8);
            if (i == 4) begin
                check("lat_vld", in_vld_r, 1);
                check("lat_beat", in_r, mk(1, 0, 4, 32'h04030201));
            end
        end
        check("throughput", cyc - t0, 8);
        wait_cycles(3);
        expect_beat("basic_b0", mk(1, 0, 4, 32'h04030201));
        expect_beat("basic_b1", mk(0, 1, 4, 32'h08070605));
        check("basic_pkt", pkt_cnt_r, 1);
        check("basic_err", err_oversize_r, 0);

        // Partial-beat packets.
        for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), i == 4);
        send_byte(8'hFF, 1'b1);
        wait_cycles(3);
        expect_beat("part_b0", mk(1, 0, 4, 32'hA3A2A1A0));
        expect_beat("part_b1", mk(0, 1, 1, 32'h000000A4));
        expect_beat("part_b2", mk(1, 1, 1, 32'h000000FF));
        check("part_pkt", pkt_cnt_r, 3);

        // Backpressure: output held for 10 cycles, source stalled.
        in_accept = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), i == 7);
            end
            begin
                int n;
                n = 0;
                while (!in_vld_r && n < 100) begin @(negedge clk); n++; end
                check("bp_vld", in_vld_r, 1);
                hold = in_r;
                repeat (10) begin
                    @(negedge clk);
                    check("bp_accept", byte_accept, 0);
                    check("bp_hold", in_r, hold);
                end
                @(posedge clk); #1;
                in_accept = 1'b1;
            end
        join
        wait_cycles(3);
        expect_beat("bp_b0", mk(1, 0, 4, 32'h13121110));
        expect_beat("bp_b1", mk(0, 1, 4, 32'h17161514));
        check("bp_pkt", pkt_cnt_r, 4);

        // Oversize: 3 beats against a 2-beat limit.
        for (int i = 0; i < 12; i++) begin
            send_byte(8'h20 + 8'(i), i == 11);
            if (i == 3) check("ovs_first", err_oversize_r, 0);
            if (i == 7) check("ovs_set", err_oversize_r, 1);
        end
        send_byte(8'h55, 1'b1);
        wait_cycles(3);
        expect_beat("ovs_b0", mk(1, 0, 4, 32'h23222120));
        expect_beat("ovs_b1", mk(0, 0, 4, 32'h27262524));
        expect_beat("ovs_b2", mk(0, 1, 4, 32'h2B2A2928));
        expect_beat("ovs_single", mk(1, 1, 1, 32'h00000055));
        check("ovs_sticky", err_oversize_r, 1);
        check("ovs_pkt", pkt_cnt_r, 6);

        // Reset mid-packet discards the partial beat.
        for (int i = 0; i < 3; i++) send_byte(8'h30 + 8'(i), 1'b0);
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        @(negedge clk);
        check("mrst_vld", in_vld_r, 0);
        check("mrst_in_r", in_r, 0);
        check("mrst_pkt", pkt_cnt_r, 0);
        check("mrst_err", err_oversize_r, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) send_byte(8'h40 + 8'(i), i == 4);
        wait_cycles(3);
        expect_beat("mrst_b0", mk(1, 0, 4, 32'h43424140));
        expect_beat("mrst_b1", mk(0, 1, 1, 32'h00000044));
        check("mrst_pkt2", pkt_cnt_r, 1);
        check("mrst_err2", err_oversize_r, 0);
        check("extra_beats", got_q.size(), 0);

        // Random soak with random gaps and downstream stalls.
        fork
            begin
                for (int p = 0; p < 20; p++) begin
                    len = (p == 0) ? 64 : int'($urandom_range(1, 64));
                    for (int i = 0; i < len; i++) begin
                        logic [7:0] b;
                        b = 8'($urandom);
                        src_q.push_back(b);
                        repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
                        send_byte(b, i == len - 1);
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    in_accept = 1'(($urandom_range(0, 1)));
                end
                in_accept = 1'b1;
            end
        join
        wait_cycles(10);

        bad_len = 0; bad_sop = 0; eops = 0; prev_eop = 1'b1;
        while (got_q.size() != 0) begin
            g = got_q.pop_front();
            if (g[36] != prev_eop) bad_sop++;
            if ((!g[35] && g[34:32] != 3'd4) || g[34:32] == 3'd0 || g[34:32] > 3'd4) bad_len++;
            for (int k = 0; k < int'(g[34:32]) && k < 4; k++) rebuilt.push_back(g[8*k +: 8]);
            if (g[35]) eops++;
            prev_eop = g[35];
        end
        check("soak_size", rebuilt.size(), src_q.size());
        mism = 0;
        for (int k = 0; k < src_q.size() && k < rebuilt.size(); k++)
            if (rebuilt[k] !== src_q[k]) mism++;
        check("soak_bytes", mism, 0);
        check("soak_len", bad_len, 0);
        check("soak_sop", bad_sop, 0);
        check("soak_eops", eops, 20);
        check("soak_pkt", pkt_cnt_r, 21);
        check("soak_err", err_oversize_r, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
